vga_timing_gen: RTL and testbench

- Programmable VGA raster timing generator driving the pixel path: beam_x/beam_y feed the hex/character decoder; vga_hsync/vga_vsync/vga_blank feed vga2dvid.
- Contains a built-in sync delay line so that syncs and blank line up with colour from a pipelined pixel source (C_sync_delay cycles of latency).
- Defaults give 640x480@60 from a 25 MHz clk_pixel.

---
 rtl/vga_timing_pkg.sv | 48 ++++
 rtl/sync_delay_line.sv | 45 ++++
 rtl/vga_timing_gen.sv | 129 ++++++++++++
 tb/tb_vga_timing_gen.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants, types and helpers for the VGA raster timing generator.
package vga_timing_pkg;

  // 640x480@60 from a 25 MHz pixel clock
  localparam int unsigned DefResX       = 640;
  localparam int unsigned DefHFrontPorch = 16;
  localparam int unsigned DefHPulse     = 96;
  localparam int unsigned DefHBackPorch = 48;
  localparam int unsigned DefResY       = 480;
  localparam int unsigned DefVFrontPorch = 10;
  localparam int unsigned DefVPulse     = 2;
  localparam int unsigned DefVBackPorch = 33;
  localparam int unsigned DefBitsX      = 10;
  localparam int unsigned DefBitsY      = 10;

  // Sync polarity: the level driven while the pulse is active
  localparam bit SyncActiveLow  = 1'b0;
  localparam bit SyncActiveHigh = 1'b1;

  localparam int unsigned MaxSyncDelay = 8;

  // One stage of the sync/blank delay line, in active-high form
  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
  } sync_bus_t;

  // Idle level of a stage: no sync pulses, blanked
  localparam sync_bus_t SyncIdle = '{hs: 1'b0, vs: 1'b0, blank: 1'b1};

  // Total pixels per line / lines per frame
  function automatic int unsigned calc_h_total(int unsigned res, int unsigned fp,
                                               int unsigned pulse, int unsigned bp);
    return res + fp + pulse + bp;
  endfunction

  function automatic int unsigned calc_v_total(int unsigned res, int unsigned fp,
                                               int unsigned pulse, int unsigned bp);
    return res + fp + pulse + bp;
  endfunction

  // True when a counter of the given width can hold 0..total-1
  function automatic bit total_fits(int unsigned total, int unsigned bits);
    return 64'(total) <= (64'd1 << bits);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Enabled shift register of configurable depth and width with a synchronous
// reset value; used to align control signals with a pipelined data path.
module sync_delay_line
  import vga_timing_pkg::*;
#(
  parameter int unsigned Depth    = 1,
  parameter int unsigned Width    = 1,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ena_i,
  input  logic [Width-1:0] din_i,
  output logic [Width-1:0] dout_o
);

  if (Depth < 1 || Depth > MaxSyncDelay) begin : g_bad_depth
    $error("sync_delay_line: Depth must be in 1..8");
  end

  logic [Depth-1:0][Width-1:0] stage_q, stage_d;

  // Shift one stage per enabled cycle, otherwise hold
  always_comb begin
    stage_d = stage_q;
    if (ena_i) begin
      stage_d[0] = din_i;
      for (int unsigned i = 1; i < Depth; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  // Stage registers; reset loads every stage with the idle value
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_q <= {Depth{ResetVal}};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout_o = stage_q[Depth-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Programmable VGA raster timing generator. beam_x/beam_y address the pixel
// source; syncs and blank are delayed by C_sync_delay enabled cycles so they
// line up with colour coming out of a pipelined pixel path.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned C_resolution_x      = DefResX,
  parameter int unsigned C_hsync_front_porch = DefHFrontPorch,
  parameter int unsigned C_hsync_pulse       = DefHPulse,
  parameter int unsigned C_hsync_back_porch  = DefHBackPorch,
  parameter int unsigned C_resolution_y      = DefResY,
  parameter int unsigned C_vsync_front_porch = DefVFrontPorch,
  parameter int unsigned C_vsync_pulse       = DefVPulse,
  parameter int unsigned C_vsync_back_porch  = DefVBackPorch,
  parameter bit          C_hsync_polarity    = SyncActiveLow,
  parameter bit          C_vsync_polarity    = SyncActiveLow,
  parameter int unsigned C_bits_x            = DefBitsX,
  parameter int unsigned C_bits_y            = DefBitsY,
  parameter int unsigned C_sync_delay        = 1
) (
  input  logic                clk_pixel,
  input  logic                reset,
  input  logic                clk_pixel_ena,
  output logic [C_bits_x-1:0] beam_x,
  output logic [C_bits_y-1:0] beam_y,
  output logic                line_start,
  output logic                frame_start,
  output logic                vga_hsync,
  output logic                vga_vsync,
  output logic                vga_blank,
  output logic                vga_de
);

  localparam int unsigned HTotal = calc_h_total(C_resolution_x, C_hsync_front_porch,
                                                C_hsync_pulse, C_hsync_back_porch);
  localparam int unsigned VTotal = calc_v_total(C_resolution_y, C_vsync_front_porch,
                                                C_vsync_pulse, C_vsync_back_porch);

  if (!total_fits(HTotal, C_bits_x)) begin : g_bad_bits_x
    $error("vga_timing_gen: C_bits_x too narrow for H_total");
  end
  if (!total_fits(VTotal, C_bits_y)) begin : g_bad_bits_y
    $error("vga_timing_gen: C_bits_y too narrow for V_total");
  end
  if (C_resolution_x < 1 || C_resolution_y < 1 || C_hsync_pulse < 1 || C_vsync_pulse < 1)
  begin : g_bad_geometry
    $error("vga_timing_gen: resolutions and sync pulses must be non-zero");
  end

  // Inclusive bounds, so no constant ever needs to hold 2**C_bits
  localparam logic [C_bits_x-1:0] HLast      = C_bits_x'(HTotal - 1);
  localparam logic [C_bits_x-1:0] HVisLast   = C_bits_x'(C_resolution_x - 1);
  localparam logic [C_bits_x-1:0] HSyncFirst = C_bits_x'(C_resolution_x + C_hsync_front_porch);
  localparam logic [C_bits_x-1:0] HSyncLast  =
      C_bits_x'(C_resolution_x + C_hsync_front_porch + C_hsync_pulse - 1);

  localparam logic [C_bits_y-1:0] VLast      = C_bits_y'(VTotal - 1);
  localparam logic [C_bits_y-1:0] VVisLast   = C_bits_y'(C_resolution_y - 1);
  localparam logic [C_bits_y-1:0] VSyncFirst = C_bits_y'(C_resolution_y + C_vsync_front_porch);
  localparam logic [C_bits_y-1:0] VSyncLast  =
      C_bits_y'(C_resolution_y + C_vsync_front_porch + C_vsync_pulse - 1);

  logic [C_bits_x-1:0] beam_x_q, beam_x_d;
  logic [C_bits_y-1:0] beam_y_q, beam_y_d;
  logic                x_wrap, y_wrap;

  sync_bus_t           sync_stage0;
  sync_bus_t           sync_dly;

  // Next raster position: x counts every enabled cycle, y on each x wrap
  always_comb begin
    x_wrap   = (beam_x_q == HLast);
    y_wrap   = (beam_y_q == VLast);
    beam_x_d = beam_x_q;
    beam_y_d = beam_y_q;
    if (clk_pixel_ena) begin
      if (x_wrap) begin
        beam_x_d = '0;
        beam_y_d = y_wrap ? '0 : beam_y_q + 1'b1;
      end else begin
        beam_x_d = beam_x_q + 1'b1;
      end
    end
  end

  // Raster counters; reset restarts the frame even mid-frame
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      beam_x_q <= '0;
      beam_y_q <= '0;
    end else begin
      beam_x_q <= beam_x_d;
      beam_y_q <= beam_y_d;
    end
  end

  // Stage-0 decode of the current position, active-high
  always_comb begin
    sync_stage0       = SyncIdle;
    sync_stage0.blank = (beam_x_q > HVisLast) || (beam_y_q > VVisLast);
    sync_stage0.hs    = (beam_x_q >= HSyncFirst) && (beam_x_q <= HSyncLast);
    sync_stage0.vs    = (beam_y_q >= VSyncFirst) && (beam_y_q <= VSyncLast);
  end

  sync_delay_line #(
    .Depth    (C_sync_delay),
    .Width    ($bits(sync_bus_t)),
    .ResetVal (SyncIdle)
  ) u_sync_delay (
    .clk_i  (clk_pixel),
    .rst_i  (reset),
    .ena_i  (clk_pixel_ena),
    .din_i  (sync_stage0),
    .dout_o (sync_dly)
  );

  // Outputs: polarity applied after the delay line; pulses only on enabled cycles
  always_comb begin
    beam_x      = beam_x_q;
    beam_y      = beam_y_q;
    line_start  = clk_pixel_ena && (beam_x_q == '0);
    frame_start = clk_pixel_ena && (beam_x_q == '0) && (beam_y_q == '0);
    vga_hsync   = sync_dly.hs ^ ~C_hsync_polarity;
    vga_vsync   = sync_dly.vs ^ ~C_vsync_polarity;
    vga_blank   = sync_dly.blank;
    vga_de      = ~sync_dly.blank;
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance (delay 1, active-low
// syncs) and a tiny 14x8 instance (delay 3, active-high syncs) share stimulus.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset;
  logic ena;

  always #20 clk = ~clk;

  logic [9:0] d_x, d_y;
  logic       d_ls, d_fs, d_hs, d_vs, d_blank, d_de;
  logic [3:0] s_x;
  logic [2:0] s_y;
  logic       s_ls, s_fs, s_hs, s_vs, s_blank, s_de;

  vga_timing_gen u_def (
    .clk_pixel     (clk),
    .reset         (reset),
    .clk_pixel_ena (ena),
    .beam_x        (d_x),
    .beam_y        (d_y),
    .line_start    (d_ls),
    .frame_start   (d_fs),
    .vga_hsync     (d_hs),
    .vga_vsync     (d_vs),
    .vga_blank     (d_blank),
    .vga_de        (d_de)
  );

  // 8x4 visible, H: fp 2 pulse 3 bp 1 (total 14), V: fp 1 pulse 2 bp 1 (total 8)
  vga_timing_gen #(
    .C_resolution_x      (8),
    .C_hsync_front_porch (2),
    .C_hsync_pulse       (3),
    .C_hsync_back_porch  (1),
    .C_resolution_y      (4),
    .C_vsync_front_porch (1),
    .C_vsync_pulse       (2),
    .C_vsync_back_porch  (1),
    .C_hsync_polarity    (1'b1),
    .C_vsync_polarity    (1'b1),
    .C_bits_x            (4),
    .C_bits_y            (3),
    .C_sync_delay        (3)
  ) u_sm (
    .clk_pixel     (clk),
    .reset         (reset),
    .clk_pixel_ena (ena),
    .beam_x        (s_x),
    .beam_y        (s_y),
    .line_start    (s_ls),
    .frame_start   (s_fs),
    .vga_hsync     (s_hs),
    .vga_vsync     (s_vs),
    .vga_blank     (s_blank),
    .vga_de        (s_de)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } exp_t;

  // Expected small-instance outputs at enabled index k (3-cycle delay, active-high)
  function automatic exp_t exp_sm(int k);
    exp_t e;
    int   d, x, y;
    e = '0;
    if (k >= 3) begin
      d    = k - 3;
      x    = d % 14;
      y    = (d / 14) % 8;
      e.hs = (x >= 10) && (x <= 12);
      e.vs = (y >= 5) && (y <= 6);
      e.de = (x < 8) && (y < 4);
    end
    return e;
  endfunction

  initial begin
    int   d_hs_low, d_de_cnt, d_ls_cnt, d_fs_cnt, d_vs_low, d_max_x, d_max_y;
    int   s_hs_cnt, s_vs_cnt, s_de_cnt, s_ls_cnt, s_fs_cnt, s_max_x, s_max_y;
    int   k;
    exp_t e;

    // ---------------- continuous enable ----------------
    reset = 1'b1;
    ena   = 1'b1;
    step();
    step();
    check_eq("rst_def_x", d_x, 0);
    check_eq("rst_def_y", d_y, 0);
    check_eq("rst_def_hs", d_hs, 1);
    check_eq("rst_def_vs", d_vs, 1);
    check_eq("rst_def_blank", d_blank, 1);
    check_eq("rst_def_de", d_de, 0);
    check_eq("rst_sm_hs", s_hs, 0);
    check_eq("rst_sm_vs", s_vs, 0);
    check_eq("rst_sm_blank", s_blank, 1);
    reset = 1'b0;

    d_hs_low = 0; d_de_cnt = 0; d_ls_cnt = 0; d_fs_cnt = 0; d_vs_low = 0;
    d_max_x = 0; d_max_y = 0;
    s_hs_cnt = 0; s_vs_cnt = 0; s_de_cnt = 0; s_ls_cnt = 0; s_fs_cnt = 0;
    s_max_x = 0; s_max_y = 0;

    for (int i = 0; i < 1600; i++) begin
      if (i == 0) begin
        check_eq("def_fs_c0", d_fs, 1);
        check_eq("def_ls_c0", d_ls, 1);
        check_eq("sm_fs_c0", s_fs, 1);
      end
      if (i == 1) begin
        check_eq("def_fs_c1", d_fs, 0);
        check_eq("def_de_c1", d_de, 1);
      end
      if (i == 640) check_eq("def_blank_c640", d_blank, 0);
      if (i == 641) check_eq("def_blank_c641", d_blank, 1);
      if (i == 656) check_eq("def_hs_c656", d_hs, 1);
      if (i == 657) check_eq("def_hs_c657", d_hs, 0);
      if (i == 752) check_eq("def_hs_c752", d_hs, 0);
      if (i == 753) check_eq("def_hs_c753", d_hs, 1);
      if (i == 800) begin
        check_eq("def_x_c800", d_x, 0);
        check_eq("def_y_c800", d_y, 1);
        check_eq("def_ls_c800", d_ls, 1);
        check_eq("def_fs_c800", d_fs, 0);
      end
      if (i == 2) check_eq("sm_blank_c2", s_blank, 1);
      if (i == 3) check_eq("sm_blank_c3", s_blank, 0);
      if (i == 12) check_eq("sm_hs_c12", s_hs, 0);
      if (i == 13) check_eq("sm_hs_c13", s_hs, 1);
      if (i == 16) check_eq("sm_hs_c16", s_hs, 0);
      if (i == 112) check_eq("sm_fs_c112", s_fs, 1);

      if (!d_hs) d_hs_low++;
      if (!d_vs) d_vs_low++;
      if (d_de) d_de_cnt++;
      if (d_ls) d_ls_cnt++;
      if (d_fs) d_fs_cnt++;
      if (int'(d_x) > d_max_x) d_max_x = int'(d_x);
      if (int'(d_y) > d_max_y) d_max_y = int'(d_y);
      if (s_hs) s_hs_cnt++;
      if (s_vs) s_vs_cnt++;
      if (s_de) s_de_cnt++;
      if (s_ls) s_ls_cnt++;
      if (s_fs) s_fs_cnt++;
      if (int'(s_x) > s_max_x) s_max_x = int'(s_x);
      if (int'(s_y) > s_max_y) s_max_y = int'(s_y);
      step();
    end

    check_eq("def_hs_low_cnt", d_hs_low, 192);
    check_eq("def_vs_low_cnt", d_vs_low, 0);
    check_eq("def_de_cnt", d_de_cnt, 1280);
    check_eq("def_ls_cnt", d_ls_cnt, 2);
    check_eq("def_fs_cnt", d_fs_cnt, 1);
    check_eq("def_max_x", d_max_x, 799);
    check_eq("def_max_y", d_max_y, 1);
    check_eq("sm_hs_cnt", s_hs_cnt, 342);
    check_eq("sm_vs_cnt", s_vs_cnt, 392);
    check_eq("sm_de_cnt", s_de_cnt, 465);
    check_eq("sm_ls_cnt", s_ls_cnt, 115);
    check_eq("sm_fs_cnt", s_fs_cnt, 15);
    check_eq("sm_max_x", s_max_x, 13);
    check_eq("sm_max_y", s_max_y, 7);

    // ---------------- gated enable: 50% then 25% duty ----------------
    for (int p = 2; p <= 4; p += 2) begin
      reset = 1'b1;
      ena   = 1'b1;
      step();
      step();
      reset = 1'b0;
      k = 0;
      for (int c = 0; c < p * 120; c++) begin
        ena = ((c % p) == 0);
        #1;
        e = exp_sm(k);
        check_eq("ena_sm_x", s_x, k % 14);
        check_eq("ena_sm_y", s_y, (k / 14) % 8);
        check_eq("ena_sm_ls", s_ls, int'(ena && (k % 14 == 0)));
        check_eq("ena_sm_fs", s_fs, int'(ena && (k % 112 == 0)));
        check_eq("ena_sm_hs", s_hs, e.hs);
        check_eq("ena_sm_vs", s_vs, e.vs);
        check_eq("ena_sm_de", s_de, e.de);
        check_eq("ena_def_x", d_x, k);
        check_eq("ena_def_fs", d_fs, int'(ena && (k == 0)));
        if (ena) k++;
        step();
      end
    end

    // ---------------- mid-frame reset ----------------
    ena   = 1'b1;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 81; i++) step();
    check_eq("mid_sm_x_pre", s_x, 11);
    check_eq("mid_sm_y_pre", s_y, 5);
    check_eq("mid_sm_vs_pre", s_vs, 1);
    reset = 1'b1;
    step();
    check_eq("mid_sm_x", s_x, 0);
    check_eq("mid_sm_y", s_y, 0);
    check_eq("mid_sm_blank", s_blank, 1);
    check_eq("mid_sm_hs", s_hs, 0);
    check_eq("mid_sm_vs", s_vs, 0);
    check_eq("mid_def_x", d_x, 0);
    check_eq("mid_def_hs", d_hs, 1);
    check_eq("mid_def_vs", d_vs, 1);
    check_eq("mid_def_blank", d_blank, 1);
    step();
    reset = 1'b0;
    #1;
    check_eq("mid_sm_fs_rel", s_fs, 1);
    check_eq("mid_def_fs_rel", d_fs, 1);
    step();
    check_eq("mid_sm_fs_next", s_fs, 0);
    check_eq("mid_sm_x_next", s_x, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
